// File: rtl/cordic_phase_sequencer.sv
// Phase-sweep driver and result collector for the CORDIC core.
// Optional build macro: CORDIC_SEQ_SAT_EN (saturating cosine negation).
module cordic_phase_sequencer #(
  parameter int CORE_LAT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         phase_init,
  input  logic [15:0]         phase_inc,
  input  logic [CNT_W-1:0]    n_samples,
  output logic signed [15:0]  Az,
  output logic                load,
  input  logic signed [15:0]  Ax,
  input  logic signed [15:0]  Ay,
  output logic signed [15:0]  cos_out,
  output logic signed [15:0]  sin_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam logic [7:0] WAIT_LOAD = 8'(CORE_LAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  state_t                state, state_nxt;
  logic [15:0]           p;
  logic [15:0]           inc;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            wcnt;
  logic                  fold_r;
  logic signed [15:0]    az_r;
  logic                  fold_now;
  logic                  last;
  logic                  wait_end;

  // Quadrants II/III are mirrored about +/-pi/2 into the core's range.
  function automatic logic signed [15:0] fold_angle(input logic [15:0] ph);
    logic [15:0] r;
    r = (ph[15] ^ ph[14]) ? (16'h8000 - ph) : ph;
    return $signed(r);
  endfunction

  function automatic logic signed [15:0] negate(input logic signed [15:0] x);
`ifdef CORDIC_SEQ_SAT_EN
    if (x == $signed(16'h8000)) return $signed(16'h7FFF);
`endif
    return -x;
  endfunction

  assign fold_now = p[15] ^ p[14];
  assign last     = (cnt == CNT_W'(1));
  assign wait_end = (wcnt == 8'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (n_samples != '0)) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: if (wait_end) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = last ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_comb begin
    load      = (state == LOAD);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    Az        = (state == LOAD) ? fold_angle(p) : az_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p       <= '0;
      inc     <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      fold_r  <= 1'b0;
      az_r    <= '0;
      cos_out <= '0;
      sin_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p    <= phase_init;
            inc  <= phase_inc;
            cnt  <= n_samples;
            done <= (n_samples == '0);
          end
        end
        LOAD: begin
          az_r   <= fold_angle(p);
          fold_r <= fold_now;
          wcnt   <= WAIT_LOAD;
        end
        WAIT: begin
          if (!wait_end) begin
            wcnt <= wcnt - 8'd1;
          end else if (!abort) begin
            cos_out <= fold_r ? negate(Ax) : Ax;
            sin_out <= Ay;
          end
        end
        OUT: begin
          // Abort wins over a same-cycle handshake: the sample is dropped.
          if (out_ready && !abort) begin
            p    <= p + inc;
            cnt  <= cnt - CNT_W'(1);
            done <= last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Directed bench for cordic_phase_sequencer: sweep, latency, back-pressure,
// sign correction, abort/reset, zero-length burst and phase wrap.
module tb_cordic_phase_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             out_ready = 1'b0;
  logic [15:0]      phase_init = '0;
  logic [15:0]      phase_inc = '0;
  logic [CNT_W-1:0] n_samples = '0;
  logic [15:0]      Ax = '0;
  logic [15:0]      Ay = '0;
  logic [15:0]      Az, cos_out, sin_out;
  logic             load, out_valid, busy, done;

  cordic_phase_sequencer #(.CORE_LAT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .phase_init(phase_init), .phase_inc(phase_inc), .n_samples(n_samples),
    .Az(Az), .load(load), .Ax(Ax), .Ay(Ay),
    .cos_out(cos_out), .sin_out(sin_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  int          load_cnt, hs_cnt, done_cnt, first_valid, start_cyc;
  int          load_cyc [16];
  logic [15:0] az_log [16];
  logic [15:0] cos_log [16];
  logic [15:0] sin_log [16];

  always @(negedge clk) begin
    if (load) begin
      if (load_cnt < 16) begin
        load_cyc[load_cnt] = cyc;
        az_log[load_cnt]   = Az;
      end
      load_cnt++;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      if (hs_cnt < 16) begin
        cos_log[hs_cnt] = cos_out;
        sin_log[hs_cnt] = sin_out;
      end
      hs_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    load_cnt = 0; hs_cnt = 0; done_cnt = 0; first_valid = -1;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] pi, input logic [15:0] pinc, input logic [CNT_W-1:0] n);
    phase_init = pi; phase_inc = pinc; n_samples = n;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    if (busy) check("idle_timeout", busy, 0);
    tick();
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!out_valid && k < max) begin
      tick();
      k++;
    end
    if (!out_valid) check("valid_timeout", out_valid, 1);
  endtask

  logic [15:0] az_exp [8] = '{16'h0000, 16'h2000, 16'h4000, 16'h2000,
                              16'h0000, 16'hE000, 16'hC000, 16'hE000};
  logic [7:0]  fold_exp = 8'b0011_1100;
`ifdef CORDIC_SEQ_SAT_EN
  logic [15:0] sat_exp = 16'h7FFF;
`else
  logic [15:0] sat_exp = 16'h8000;
`endif

  logic [15:0] hold_cos, hold_sin;
  logic        stable;

  initial begin
    clear_mon();
    #2 rst = 1'b0;
    tick(3);
    check("rst_az", Az, 0);
    check("rst_load", load, 0);
    check("rst_cos", cos_out, 0);
    check("rst_sin", sin_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    tick(2);

    // Eight-sample sweep with fold pattern and latency.
    Ax = 16'h3000; Ay = 16'h1000; out_ready = 1'b1;
    clear_mon();
    do_start(16'h0000, 16'h2000, 8);
    wait_idle(400);
    check("sweep_loads", load_cnt, 8);
    check("sweep_hs", hs_cnt, 8);
    check("sweep_done", done_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep_az%0d", i), az_log[i], az_exp[i]);
      check($sformatf("sweep_cos%0d", i), cos_log[i], fold_exp[i] ? 16'hD000 : 16'h3000);
      check($sformatf("sweep_sin%0d", i), sin_log[i], 16'h1000);
    end
    check("lat_load1", load_cyc[0] - start_cyc, 1);
    check("lat_valid", first_valid - start_cyc, 18);
    check("lat_load2", load_cyc[1] - start_cyc, 19);

    // Back-pressure: output held, no new load, phase frozen.
    clear_mon();
    out_ready = 1'b0; Ax = 16'h1234; Ay = 16'h0567;
    do_start(16'h1000, 16'h1000, 2);
    wait_valid(100);
    hold_cos = cos_out; hold_sin = sin_out;
    Ax = 16'h2222; Ay = 16'h0333;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!out_valid || cos_out !== hold_cos || sin_out !== hold_sin || load) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_cos", hold_cos, 16'h1234);
    check("bp_sin", hold_sin, 16'h0567);
    check("bp_loads", load_cnt, 1);
    check("bp_az_hold", Az, 16'h1000);
    out_ready = 1'b1;
    wait_idle(100);
    check("bp_az2", az_log[1], 16'h2000);
    check("bp_cos2", cos_log[1], 16'h2222);
    check("bp_hs", hs_cnt, 2);
    check("bp_done", done_cnt, 1);

    // Negating the most negative cosine.
    clear_mon();
    Ax = 16'h8000; Ay = 16'h0000;
    do_start(16'h4000, 16'h0000, 1);
    wait_idle(100);
    check("sat_az", az_log[0], 16'h4000);
    check("sat_cos", cos_log[0], sat_exp);

    // Abort during WAIT of sample 3, then restart.
    clear_mon();
    Ax = 16'h1000; Ay = 16'h0100;
    do_start(16'h0000, 16'h1000, 5);
    for (int k = 0; k < 200 && load_cnt < 3; k++) tick();
    tick(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    tick(25);
    check("abort_valid", out_valid, 0);
    check("abort_hs", hs_cnt, 2);
    check("abort_done", done_cnt, 0);
    clear_mon();
    do_start(16'h3000, 16'h1000, 1);
    wait_idle(100);
    check("restart_az", az_log[0], 16'h3000);
    check("restart_loads", load_cnt, 1);
    check("restart_done", done_cnt, 1);

    // Asynchronous reset while a sample is pending.
    clear_mon();
    out_ready = 1'b0; Ax = 16'h1111; Ay = 16'h2222;
    do_start(16'h1000, 16'h0000, 2);
    wait_valid(100);
    #2 rst = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cos", cos_out, 0);
    check("mrst_sin", sin_out, 0);
    check("mrst_az", Az, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("mrst_done", done_cnt, 0);

    // Zero-length burst.
    clear_mon();
    do_start(16'h1234, 16'h0001, 0);
    check("zero_done_now", done, 1);
    tick(3);
    check("zero_loads", load_cnt, 0);
    check("zero_done", done_cnt, 1);
    check("zero_busy", busy, 0);

    // Phase accumulator wrap.
    clear_mon();
    out_ready = 1'b1; Ax = 16'h0100; Ay = 16'h0200;
    do_start(16'hF000, 16'h2000, 2);
    wait_idle(100);
    check("wrap_az0", az_log[0], 16'hF000);
    check("wrap_az1", az_log[1], 16'h1000);
    check("wrap_cos1", cos_log[1], 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
